// File: rtl/lab3_cache_line_xfer.sv
// Line transfer engine: turns one cache-line refill or writeback into WORDS_PER_LINE
// back-to-back 4B memory transactions and folds the responses into one line response.
module lab3_cache_line_xfer #(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                line_req_val,
  output logic                                line_req_rdy,
  input  logic                                line_req_type,
  input  logic [31:0]                         line_req_addr,
  input  logic [32*WORDS_PER_LINE-1:0]        line_req_data,
  output logic                                line_resp_val,
  input  logic                                line_resp_rdy,
  output logic                                line_resp_type,
  output logic [32*WORDS_PER_LINE-1:0]        line_resp_data,
  output logic                                mem_req_val,
  input  logic                                mem_req_rdy,
  output logic [76:0]                         mem_req_msg,
  input  logic                                mem_resp_val,
  output logic                                mem_resp_rdy,
  input  logic [46:0]                         mem_resp_msg,
  output logic [1:0]                          debug_state,
  output logic [$clog2(WORDS_PER_LINE):0]     debug_issue_cnt,
  output logic [$clog2(WORDS_PER_LINE):0]     debug_recv_cnt
);

  // Every interface uses valid/ready: a transfer fires on the rising edge where both are
  // high, a producer holds valid and payload stable until it fires, and no ready here
  // depends combinationally on the valid of its own interface.

  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] FULL = CW'(WORDS_PER_LINE);
  localparam logic [31:0] ALIGN_MASK = ~32'(4*WORDS_PER_LINE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                  state;
  logic [CW-1:0]               issue_cnt;
  logic [CW-1:0]               recv_cnt;
  logic                        type_q;
  logic [31:0]                 base_q;
  logic [32*WORDS_PER_LINE-1:0] line_buf;

  logic          line_req_fire;
  logic          line_resp_fire;
  logic          mem_req_fire;
  logic          mem_resp_fire;
  logic [IW-1:0] issue_idx;
  logic [IW-1:0] resp_idx;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic          resp_unused;

  assign line_req_rdy   = reset && (state == IDLE);
  assign mem_req_val    = (state == XFER) && (issue_cnt < FULL);
  assign mem_resp_rdy   = (state == XFER);
  assign line_resp_val  = (state == RESP);
  assign line_resp_type = type_q;
  assign line_resp_data = line_buf;

  assign line_req_fire  = line_req_val  && line_req_rdy;
  assign line_resp_fire = line_resp_val && line_resp_rdy;
  assign mem_req_fire   = mem_req_val   && mem_req_rdy;
  assign mem_resp_fire  = mem_resp_val  && mem_resp_rdy;

  // Word slot comes from the response opaque, so out-of-order returns land correctly.
  assign issue_idx = issue_cnt[IW-1:0];
  assign resp_idx  = mem_resp_msg[36 +: IW];
  assign req_addr  = base_q + (32'(issue_idx) << 2);
  assign req_data  = type_q ? line_buf[{issue_idx, 5'd0} +: 32] : 32'h0;

  // Request layout {type[3], opaque[8], addr[32], len[2], data[32]}.
  assign mem_req_msg = {3'(type_q), 8'(issue_cnt), req_addr, 2'b00, req_data};

  // Response type, test and len fields carry nothing this block needs.
  assign resp_unused = ^{mem_resp_msg[46:36+IW], mem_resp_msg[35:32]};

  assign debug_state     = state;
  assign debug_issue_cnt = issue_cnt;
  assign debug_recv_cnt  = recv_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      type_q    <= 1'b0;
      base_q    <= 32'h0;
      line_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_req_fire) begin
            type_q    <= line_req_type;
            base_q    <= line_req_addr & ALIGN_MASK;
            line_buf  <= line_req_data;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (mem_req_fire) begin
            issue_cnt <= issue_cnt + CW'(1);
          end
          if (mem_resp_fire) begin
            recv_cnt <= recv_cnt + CW'(1);
            if (!type_q) begin
              line_buf[{resp_idx, 5'd0} +: 32] <= mem_resp_msg[31:0];
            end
            if (recv_cnt == LAST) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (line_resp_fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_cache_line_xfer.sv
// Bench for lab3_cache_line_xfer: directed scenarios plus randomized lines against a
// word-addressed memory model, a request scoreboard and a line-response scoreboard.
module tb_lab3_cache_line_xfer;

  localparam int W   = 4;
  localparam int LW  = 32*W;
  localparam int CW  = $clog2(W) + 1;
  localparam int CKW = (LW + 1 > 77) ? LW + 1 : 77;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_req_val = 1'b0;
  logic          line_req_rdy;
  logic          line_req_type = 1'b0;
  logic [31:0]   line_req_addr = 32'h0;
  logic [LW-1:0] line_req_data = '0;
  logic          line_resp_val;
  logic          line_resp_rdy = 1'b0;
  logic          line_resp_type;
  logic [LW-1:0] line_resp_data;
  logic          mem_req_val;
  logic          mem_req_rdy = 1'b0;
  logic [76:0]   mem_req_msg;
  logic          mem_resp_val = 1'b0;
  logic          mem_resp_rdy;
  logic [46:0]   mem_resp_msg = '0;
  logic [1:0]    debug_state;
  logic [CW-1:0] debug_issue_cnt;
  logic [CW-1:0] debug_recv_cnt;

  lab3_cache_line_xfer #(.WORDS_PER_LINE(W)) dut (
    .clk(clk), .reset(reset),
    .line_req_val(line_req_val), .line_req_rdy(line_req_rdy),
    .line_req_type(line_req_type), .line_req_addr(line_req_addr),
    .line_req_data(line_req_data),
    .line_resp_val(line_resp_val), .line_resp_rdy(line_resp_rdy),
    .line_resp_type(line_resp_type), .line_resp_data(line_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .debug_state(debug_state), .debug_issue_cnt(debug_issue_cnt),
    .debug_recv_cnt(debug_recv_cnt)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [76:0]   exp_q[$];
  logic [LW:0]   line_exp_q[$];
  logic [31:0]   mem_model [logic [31:0]];
  logic [LW:0]   last_resp;
  int            acc_cyc = 0;

  int resp_mode   = 0;  // 0: in order, 1 cycle; 1: random order/delay; 2: forced order
  bit rdy_random  = 1'b0;
  int stall_at    = -1;
  int stall_len   = 0;
  int req_fires   = 0;
  int forced_order[W] = '{2, 0, 3, 1};
  int forced_k    = 0;

  task automatic check(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5EED_0000);
  endfunction

  // Expected word requests and line response, straight from the line-transfer rules.
  task automatic push_expect(input logic t, input logic [31:0] a, input logic [LW-1:0] d);
    logic [31:0] base;
    logic [31:0] wa;
    logic [LW-1:0] line;
    base = a & ~32'(4*W - 1);
    line = '0;
    for (int i = 0; i < W; i++) begin
      wa = base + 32'(4*i);
      exp_q.push_back({3'(t), 8'(i), wa, 2'b00, t ? d[32*i +: 32] : 32'h0});
      line[32*i +: 32] = t ? d[32*i +: 32] : mem_rd(wa);
    end
    line_exp_q.push_back({t, line});
  endtask

  // ---------------- memory responder ----------------
  logic [7:0]  pend_op[$];
  logic [31:0] pend_data[$];
  bit          presenting = 1'b0;
  int          stall_left = 0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      pend_op.delete();
      pend_data.delete();
      presenting   = 1'b0;
      mem_resp_val = 1'b0;
      stall_left   = 0;
      continue;
    end
    if (mem_resp_val && mem_resp_rdy) presenting = 1'b0;
    if (mem_req_val && mem_req_rdy) begin
      logic [76:0] m;
      logic [31:0] rd;
      m = mem_req_msg;
      req_fires++;
      check("mem_req_expected", CKW'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("mem_req_msg", m, exp_q.pop_front());
      if (m[76:74] == 3'd1) begin
        mem_model[m[65:34]] = m[31:0];
        rd = 32'h0;
      end else begin
        rd = mem_rd(m[65:34]);
      end
      pend_op.push_back(m[73:66]);
      pend_data.push_back(rd);
      if (req_fires == stall_at) stall_left = stall_len;
    end
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      mem_req_rdy = 1'b0;
      stall_left--;
    end else begin
      mem_req_rdy = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (!presenting && pend_op.size() > 0) begin
      int pick;
      pick = -1;
      case (resp_mode)
        0: pick = 0;
        1: if ($urandom_range(0, 1) == 1) pick = int'($urandom_range(0, pend_op.size() - 1));
        default: begin
          foreach (pend_op[j])
            if (forced_k < W && pend_op[j] == 8'(forced_order[forced_k])) pick = j;
        end
      endcase
      if (pick >= 0) begin
        // Random type/test bits must be ignored by the block.
        mem_resp_msg = {3'($urandom_range(0, 7)), pend_op[pick], 2'($urandom_range(0, 3)),
                        2'b00, pend_data[pick]};
        pend_op.delete(pick);
        pend_data.delete(pick);
        presenting = 1'b1;
        if (resp_mode == 2) forced_k++;
      end
    end
    mem_resp_val = presenting;
  end

  // ---------------- protocol monitor ----------------
  logic        prev_mreq_stall = 1'b0;
  logic [76:0] prev_mreq_msg = '0;
  logic        prev_lresp_stall = 1'b0;
  logic [LW:0] prev_lresp = '0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      prev_mreq_stall  = 1'b0;
      prev_lresp_stall = 1'b0;
      continue;
    end
    if (prev_mreq_stall) begin
      check("mem_req_hold_val", mem_req_val, 1);
      check("mem_req_hold_msg", mem_req_msg, prev_mreq_msg);
    end
    if (prev_lresp_stall) begin
      check("line_resp_hold_val", line_resp_val, 1);
      check("line_resp_hold_data", {line_resp_type, line_resp_data}, prev_lresp);
    end
    if (mem_req_val || mem_resp_rdy || line_resp_val) check("line_req_rdy_busy", line_req_rdy, 0);
    prev_mreq_stall  = mem_req_val && !mem_req_rdy;
    prev_mreq_msg    = mem_req_msg;
    prev_lresp_stall = line_resp_val && !line_resp_rdy;
    prev_lresp       = {line_resp_type, line_resp_data};
  end

  // ---------------- driver tasks ----------------
  task automatic send_line(input logic t, input logic [31:0] a, input logic [LW-1:0] d);
    int n;
    push_expect(t, a, d);
    @(posedge clk);
    #1;
    req_fires     = 0;
    line_req_type = t;
    line_req_addr = a;
    line_req_data = d;
    line_req_val  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_req_rdy && n < 100);
    check("line_req_accept", line_req_rdy, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    line_req_val = 1'b0;
  endtask

  task automatic recv_line(input int stall, output int lat);
    int n;
    logic [LW:0] e;
    lat = -1;
    line_resp_rdy = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_resp_val && n < 400);
    check("line_resp_seen", line_resp_val, 1);
    if (!line_resp_val) return;
    lat = cyc - acc_cyc;
    repeat (stall) @(negedge clk);
    @(posedge clk);
    #1;
    line_resp_rdy = 1'b1;
    @(negedge clk);
    e = (line_exp_q.size() > 0) ? line_exp_q.pop_front() : 'x;
    last_resp = {line_resp_type, line_resp_data};
    check("line_resp_data", last_resp, e);
    @(posedge clk);
    #1;
    line_resp_rdy = 1'b0;
    @(negedge clk);
    check("line_resp_once", line_resp_val, 0);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [LW-1:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [LW-1:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [LW-1:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

  initial begin
    int lat;
    int n;
    logic [LW-1:0] d;
    logic [31:0] a;
    logic t;

    for (int i = 0; i < W; i++) begin
      mem_model[32'h1000 + 32'(4*i)] = 32'hA0 + 32'(i);
      mem_model[32'h3000 + 32'(4*i)] = 32'hB0 + 32'(i);
    end

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_line_req_rdy", line_req_rdy, 0);
    check("rst_mem_req_val", mem_req_val, 0);
    check("rst_mem_resp_rdy", mem_resp_rdy, 0);
    check("rst_line_resp_val", line_resp_val, 0);
    check("rst_line_resp_data", {line_resp_type, line_resp_data}, 0);
    check("rst_mem_req_msg", mem_req_msg, 0);
    check("rst_state", debug_state, 0);
    check("rst_counters", {debug_issue_cnt, debug_recv_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_line_req_rdy", line_req_rdy, 1);

    // Refill from an unaligned address, zero-wait memory.
    send_line(1'b0, 32'h0000_1004, '0);
    recv_line(0, lat);
    check("t1_latency", lat, W + 2);
    check("t1_data", last_resp, {1'b0, LINE_A});
    check("t1_req_count", req_fires, W);

    // Writeback, then inspect memory.
    send_line(1'b1, 32'h0000_2000, LINE_D);
    recv_line(0, lat);
    check("t2_type", last_resp[LW], 1);
    check("t2_echo", last_resp[LW-1:0], LINE_D);
    for (int i = 0; i < W; i++)
      check("t2_mem", mem_rd(32'h2000 + 32'(4*i)), 32'hD0 + 32'(i));

    // Out-of-order responses 2,0,3,1.
    resp_mode = 2;
    forced_k  = 0;
    send_line(1'b0, 32'h0000_1008, '0);
    recv_line(0, lat);
    check("t3_data", last_resp, {1'b0, LINE_A});
    check("t3_order_done", forced_k, W);
    resp_mode = 0;

    // Request stall after the second request plus response backpressure.
    stall_at  = 2;
    stall_len = 3;
    send_line(1'b0, 32'h0000_1000, '0);
    recv_line(5, lat);
    check("t4_req_count", req_fires, W);
    check("t4_latency", lat, W + 2 + 3);
    check("t4_data", last_resp, {1'b0, LINE_A});
    stall_at = -1;

    // Reset mid-transfer after two requests.
    send_line(1'b0, 32'h0000_1000, '0);
    n = 0;
    while (debug_issue_cnt != CW'(2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_two_issued", debug_issue_cnt, 2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    line_exp_q.delete();
    repeat (2) @(negedge clk);
    check("t5_rst_line_req_rdy", line_req_rdy, 0);
    check("t5_rst_mem_req_val", mem_req_val, 0);
    check("t5_rst_counters", {debug_issue_cnt, debug_recv_cnt}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_line_req_rdy", line_req_rdy, 1);
    check("t5_counters", {debug_issue_cnt, debug_recv_cnt}, 0);
    send_line(1'b0, 32'h0000_3000, '0);
    recv_line(0, lat);
    check("t5_data", last_resp, {1'b0, LINE_B});

    // Back-to-back: second line waits with valid high through the first.
    d = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    send_line(1'b1, 32'h0000_4000, d);
    push_expect(1'b0, 32'h0000_1000, '0);
    line_req_type = 1'b0;
    line_req_addr = 32'h0000_1000;
    line_req_val  = 1'b1;
    line_resp_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_resp_val && n < 100);
    check("b2b_first_seen", line_resp_val, 1);
    check("b2b_first_data", {line_resp_type, line_resp_data},
          (line_exp_q.size() > 0) ? line_exp_q.pop_front() : 'x);
    @(negedge clk);
    check("b2b_accept_next_cycle", line_req_rdy, 1);
    check("b2b_single_resp", line_resp_val, 0);
    acc_cyc   = cyc;
    req_fires = 0;
    @(posedge clk);
    #1;
    line_req_val  = 1'b0;
    line_resp_rdy = 1'b0;
    recv_line(0, lat);
    check("b2b_latency", lat, W + 2);
    check("b2b_second_data", last_resp, {1'b0, LINE_A});

    // Randomized lines: random order/delay memory, random stalls, wrap-around addresses.
    resp_mode  = 1;
    rdy_random = 1'b1;
    for (int k = 0; k < 40; k++) begin
      t = 1'($urandom_range(0, 1));
      a = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0000_5000) | 32'($urandom_range(0, 255));
      for (int i = 0; i < W; i++) d[32*i +: 32] = $urandom;
      send_line(t, a, d);
      recv_line(int'($urandom_range(0, 3)), lat);
      check("rand_req_count", req_fires, W);
    end
    check("exp_q_drained", CKW'(exp_q.size() + line_exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lab3_cache_line_xfer.md
Name: lab3_cache_line_xfer

Overview:
- Memory-side neighbour of the cache base. Converts one line-level refill or writeback from the cache controller into WORDS_PER_LINE back-to-back 4B memory transactions.
- Collects the memory responses and returns a single line-level response.
- Sits between the cache's line interface and the main-memory 4B request/response ports (mem_req_4B_t / mem_resp_4B_t).

Parameters:
- WORDS_PER_LINE, 4, number of 32-bit words per cache line; power of two, 2..16.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-low (0 = reset asserted)
- line_req_val  in  1  line request valid
- line_req_rdy  out  1  line request ready
- line_req_type  in  1  0 = refill (read line), 1 = writeback (write line)
- line_req_addr  in  32  line address; low log2(4*WORDS_PER_LINE) bits are ignored and treated as zero
- line_req_data  in  32*WORDS_PER_LINE  writeback data; word i in bits [32i+31:32i]
- line_resp_val  out  1  line response valid
- line_resp_rdy  in  1  line response ready
- line_resp_type  out  1  copy of the latched request type
- line_resp_data  out  32*WORDS_PER_LINE  refill data (read) or echo of the written data (write)
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_msg  out  mem_req_4B_t (77)  memory request message
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  memory response ready
- mem_resp_msg  in  mem_resp_4B_t (47)  memory response message

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; issue_cnt=0, recv_cnt=0; line buffer, type and address registers cleared.
- Reset values of outputs: line_req_rdy=0 while reset is asserted; all other valids/readies=0; data outputs=0.
- Counters are $clog2(WORDS_PER_LINE)+1 bits wide. Handshakes fire on val&rdy at the rising edge. No combinational path from any input valid to the same-interface ready.

State IDLE:
- line_req_rdy=1 (when not in reset).
- On line_req fire: latch type, aligned base address and line_req_data into the line buffer; clear both counters; go to XFER.

State XFER:
- mem_req_val=1 while issue_cnt<WORDS_PER_LINE.
- mem_req_msg fields: type = read(0) for refill, write(1) for writeback; opaque = issue_cnt; addr = base + 4*issue_cnt; len = 0 (full 4B); data = buffer word[issue_cnt] for write, 0 for read.
- issue_cnt increments on each mem_req fire.
- mem_resp_rdy=1 throughout XFER.
- On mem_resp fire: index = opaque[log2(W)-1:0]. For refill, buffer word[index] <= resp data. recv_cnt increments.
- Responses may arrive out of order; placement is by opaque only.
- A request fire and a response fire in the same cycle are both honoured.
- When the fire of the final response (recv_cnt = W-1 -> W) occurs, go to RESP.

State RESP:
- line_resp_val=1; line_resp_data = buffer; line_resp_type = latched type.
- On line_resp fire: go to IDLE.
- line_resp_val holds, with data stable, until accepted; backpressure of any length is allowed.

Other rules:
- mem_resp_rdy=0 and mem_req_val=0 in IDLE and RESP. Stray responses are not accepted.
- Latency, zero-wait memory with a 1-cycle response: request accepted cycle 0; mem reqs cycles 1..W; last resp cycle W+1; line_resp_val cycle W+2.
- mem_req_rdy stall: the current request holds with a stable message; issue_cnt does not advance.
- Reset mid-transfer: the in-flight line is abandoned and the block returns to IDLE. Memory must be reset concurrently, because outstanding responses are not drained.
- Response type and test fields are ignored.
- Address arithmetic is modulo 2^32; a line never crosses its aligned boundary.

Test Plan:
- Refill at 0x0000_1004 (aligned to 0x1000), memory holds 0xA0,0xA1,0xA2,0xA3 at 0x1000..0x100C, 1-cycle response -> mem reads to 0x1000,0x1004,0x1008,0x100C with opaque 0..3; line_resp_data = {0xA3,0xA2,0xA1,0xA0}; line_resp_val asserted in cycle 6.
- Writeback of {0xD3,0xD2,0xD1,0xD0} to 0x2000 -> four write reqs, word i carries 0xD0+i to 0x2000+4i; line_resp_type=1; memory contents verified.
- Out-of-order responses (opaque order 2,0,3,1) on a refill -> each word lands at its opaque index; data identical to the in-order case.
- mem_req_rdy low for 3 cycles after the 2nd request, and line_resp_rdy low for 5 cycles -> no duplicate or lost requests, messages stable while stalled, exactly one line_resp fire.
- Assert reset after 2 of 4 requests, release, then issue a new refill to 0x3000 -> after release: line_req_rdy=1, counters 0, new line returned correctly.
- Back-to-back line requests -> the second is accepted in the cycle after the first line_resp fire; line_req_rdy=0 throughout XFER and RESP.
